// File: rtl/i2s_adc_rx.sv
// Master-mode I2S capture from a stereo ADC: derives mclk/sclk/lrck from ck_en, deserialises sdout into
// WIDTH-bit samples and presents one pair per frame with a single-cycle valid. Optional DC blocker: I2S_ADC_RX_HPF_EN.
module i2s_adc_rx #(
  parameter int WIDTH         = 16,
  parameter int SETTLE_FRAMES = 4,
  parameter int HPF_SHIFT     = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    ck_en,
  input  logic                    adc_sdout,
  output logic                    mclk,
  output logic                    sclk,
  output logic                    lrck,
  output logic signed [WIDTH-1:0] snd_l,
  output logic signed [WIDTH-1:0] snd_r,
  output logic                    snd_valid,
  output logic                    locked
);

  typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

  localparam logic [5:0] LAST_SLOT   = 6'(WIDTH);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_FRAMES);

  state_t           state, state_nxt;
  logic [8:0]       phase;
  logic [7:0]       frame_ctr;
  logic [WIDTH-1:0] shift_q, shift_nxt, hold_l, hold_r;
  logic [4:0]       slot;
  logic             active, step, wrap, in_word, capture, last_bit, emit;
  logic signed [WIDTH-1:0] out_l, out_r;

  assign active    = (state != IDLE) && en;
  assign step      = active && ck_en;
  assign wrap      = step && (phase == 9'd511);
  assign slot      = phase[7:3];
  assign in_word   = ({1'b0, slot} >= 6'd1) && ({1'b0, slot} <= LAST_SLOT);
  assign shift_nxt = WIDTH'({shift_q, adc_sdout});

  assign mclk = phase[0];
  assign sclk = phase[2];
  assign lrck = phase[8];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = SYNC;
      SYNC:    if (!en) state_nxt = IDLE;
               else if (wrap && frame_ctr == SETTLE_LAST) state_nxt = RUN;
      RUN:     if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode: sample on the step that raises sclk, emit on RUN wraps
  always_comb begin
    capture  = step && (phase[2:0] == 3'b011) && in_word;
    last_bit = capture && ({1'b0, slot} == LAST_SLOT);
    emit     = wrap && (state_nxt == RUN);
  end

`ifdef I2S_ADC_RX_HPF_EN
  logic signed [WIDTH+7:0] dc_l, dc_r;

  function automatic logic signed [WIDTH+7:0] dc_next(input logic signed [WIDTH-1:0] x,
                                                      input logic signed [WIDTH+7:0] dc);
    logic signed [WIDTH+8:0] diff;
    diff = $signed({x[WIDTH-1], x, 8'b0}) - $signed({dc[WIDTH+7], dc});
    diff = diff >>> HPF_SHIFT;
    return dc + diff[WIDTH+7:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_sub(input logic signed [WIDTH-1:0] x,
                                                      input logic signed [WIDTH+7:0] dc);
    logic [WIDTH:0] d;
    d = {x[WIDTH-1], x} - {dc[WIDTH+7], dc[WIDTH+7:8]};
    if (d[WIDTH] != d[WIDTH-1])
      return d[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    return d[WIDTH-1:0];
  endfunction

  assign out_l = sat_sub(hold_l, dc_l);
  assign out_r = sat_sub(hold_r, dc_r);

  always_ff @(posedge clk) begin
    if (rst || !active) begin
      dc_l <= '0;
      dc_r <= '0;
    end else if (emit) begin
      dc_l <= dc_next(hold_l, dc_l);
      dc_r <= dc_next(hold_r, dc_r);
    end
  end
`else
  assign out_l = hold_l;
  assign out_r = hold_r;
`endif

  // Datapath; leaving the active states discards any partial word
  always_ff @(posedge clk) begin
    if (rst) begin
      phase     <= '0;
      frame_ctr <= '0;
      shift_q   <= '0;
      hold_l    <= '0;
      hold_r    <= '0;
      snd_l     <= '0;
      snd_r     <= '0;
      snd_valid <= 1'b0;
      locked    <= 1'b0;
    end else begin
      snd_valid <= emit;
      locked    <= (state_nxt == RUN);
      if (!active) begin
        phase     <= '0;
        frame_ctr <= '0;
        shift_q   <= '0;
      end else if (ck_en) begin
        phase <= phase + 9'd1;
        if (wrap && state == SYNC) frame_ctr <= frame_ctr + 8'd1;
        if (capture) shift_q <= shift_nxt;
        if (last_bit) begin
          if (phase[8]) hold_r <= shift_nxt;
          else          hold_l <= shift_nxt;
        end
      end
      if (emit) begin
        snd_l <= out_l;
        snd_r <= out_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: an I2S ADC model watches lrck/sclk and serves per-frame words; checks compare
// each valid pulse against the words the model sent in that frame.
module tb_i2s_adc_rx;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, ck_en = 1'b0, adc_sdout = 1'b0;
  logic mclk, sclk, lrck, snd_valid, locked;
  logic signed [15:0] snd_l, snd_r;

  i2s_adc_rx dut (
    .clk(clk), .rst(rst), .en(en), .ck_en(ck_en), .adc_sdout(adc_sdout),
    .mclk(mclk), .sclk(sclk), .lrck(lrck),
    .snd_l(snd_l), .snd_r(snd_r), .snd_valid(snd_valid), .locked(locked)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ck_div = 1, ck_cnt = 0;

  // ADC model state
  int          slot = 0;
  logic        prev_sclk = 1'b0, prev_lrck = 1'b0;
  bit          mode_rand = 1'b0, slot0_bit = 1'b0, fill_bit = 1'b0;
  logic [15:0] fix_l = '0, fix_r = '0, cur_l = '0, cur_r = '0;
  logic [15:0] exp_l, exp_r;

  initial forever begin
    @(negedge clk);
    ck_cnt++;
    ck_en = (ck_cnt % ck_div == 0);
  end

  task automatic new_frame();
    if (mode_rand) begin
      cur_l = 16'($urandom);
      cur_r = 16'($urandom);
    end else begin
      cur_l = fix_l;
      cur_r = fix_r;
    end
  endtask

  function automatic logic adc_bit(input logic [15:0] w, input int s);
    if (s == 0)  return mode_rand ? 1'($urandom) : slot0_bit;
    if (s <= 16) return w[16-s];
    return mode_rand ? 1'($urandom) : fill_bit;
  endfunction

  // ADC: a word starts on each lrck edge, bits change on sclk falling edges, MSB one slot after the edge
  initial forever begin
    @(negedge clk);
    if (lrck !== prev_lrck) begin
      slot = 0;
      if (!lrck) new_frame();
    end else if (prev_sclk && !sclk) begin
      slot++;
    end
    prev_lrck = lrck;
    prev_sclk = sclk;
    adc_sdout = adc_bit(lrck ? cur_r : cur_l, slot);
  end

  task automatic wait_valid(input int budget, output int n, output bit ok);
    n = 0;
    ok = 1'b0;
    while (n < budget && !ok) begin
      @(posedge clk); #1;
      n++;
      if (snd_valid) ok = 1'b1;
    end
  endtask

  task automatic check_valid(input string name, input int budget, input int exp_n);
    int n; bit ok;
    wait_valid(budget, n, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: no snd_valid within %0d cycles", name, budget);
      return;
    end
    if (exp_n > 0) begin
      checks++;
      if (n !== exp_n) begin errors++; $display("FAIL %s spacing: got %0d want %0d", name, n, exp_n); end
    end
    exp_l = cur_l;
    exp_r = cur_r;
    checks++;
    if (snd_l !== exp_l || snd_r !== exp_r) begin
      errors++;
      $display("FAIL %s data: got %h/%h want %h/%h", name, snd_l, snd_r, exp_l, exp_r);
    end
    checks++;
    if (locked !== 1'b1) begin errors++; $display("FAIL %s locked: got %b want 1", name, locked); end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mclk, sclk, lrck, snd_valid, locked} !== 5'b0 || snd_l !== 16'sd0 || snd_r !== 16'sd0) begin
      errors++;
      $display("FAIL reset: clk/valid/locked=%b l=%h r=%h want all zero", {mclk, sclk, lrck, snd_valid, locked}, snd_l, snd_r);
    end
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({mclk, sclk, lrck} !== 3'b000) begin errors++; $display("FAIL idle_hold: clocks=%b want 000", {mclk, sclk, lrck}); end
  endtask

  task automatic test_capture();
    mode_rand = 1'b0; fix_l = 16'h8001; fix_r = 16'h7FFE; slot0_bit = 1'b1; fill_bit = 1'b1;
    new_frame();
    en = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL sync_locked: got %b want 0", locked); end
    check_valid("first_valid", 3000, 5 * 512);  // one IDLE->SYNC cycle already consumed
    if (snd_l !== 16'h8001) begin errors++; $display("FAIL capture_l: got %h want 8001", snd_l); end
    checks++;
    check_valid("capture_next", 600, 512);
  endtask

  task automatic test_clocks();
    int mt = 0, sr = 0, lh = 0, first_hi = -1;
    logic pm = mclk, ps = sclk;
    for (int k = 1; k <= 512; k++) begin
      @(posedge clk); #1;
      if (mclk !== pm) mt++;
      if (sclk && !ps) sr++;
      if (lrck) begin lh++; if (first_hi < 0) first_hi = k; end
      pm = mclk; ps = sclk;
    end
    checks++;
    if (mt !== 512) begin errors++; $display("FAIL mclk_toggles: got %0d want 512", mt); end
    checks++;
    if (sr !== 64) begin errors++; $display("FAIL sclk_rises: got %0d want 64", sr); end
    checks++;
    if (lh !== 256 || first_hi !== 256) begin errors++; $display("FAIL lrck_shape: high %0d first %0d want 256/256", lh, first_hi); end
  endtask

  task automatic test_random();
    mode_rand = 1'b1;
    for (int i = 0; i < 8; i++) check_valid("random", 600, 512);
  endtask

  task automatic test_slot_align();
    mode_rand = 1'b0; fix_l = 16'h0000; fix_r = 16'h0000; slot0_bit = 1'b1; fill_bit = 1'b0;
    check_valid("align_sync0", 600, 512);
    check_valid("align_zero", 600, 512);
    checks++;
    if (snd_l !== 16'h0000 || snd_r !== 16'h0000) begin errors++; $display("FAIL slot0_ignored: got %h/%h want 0000/0000", snd_l, snd_r); end
    fix_l = 16'h0001; fix_r = 16'h0001; slot0_bit = 1'b0;
    check_valid("align_sync1", 600, 512);
    check_valid("align_lsb", 600, 512);
    checks++;
    if (snd_l !== 16'h0001 || snd_r !== 16'h0001) begin errors++; $display("FAIL slot16_lsb: got %h/%h want 0001/0001", snd_l, snd_r); end
  endtask

  task automatic test_abort();
    int nv = 0;
    logic [15:0] keep_l = exp_l, keep_r = exp_r;
    repeat (300) @(posedge clk);
    #1;
    en = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mclk, sclk, lrck, locked, snd_valid} !== 5'b0) begin
      errors++; $display("FAIL abort_state: clocks/locked/valid=%b want 00000", {mclk, sclk, lrck, locked, snd_valid});
    end
    checks++;
    if (snd_l !== keep_l || snd_r !== keep_r) begin errors++; $display("FAIL abort_hold: got %h/%h want %h/%h", snd_l, snd_r, keep_l, keep_r); end
    repeat (600) begin @(posedge clk); #1; if (snd_valid) nv++; end
    checks++;
    if (nv !== 0) begin errors++; $display("FAIL abort_no_valid: got %0d pulses want 0", nv); end
    mode_rand = 1'b1;
    en = 1'b1;
    check_valid("reenable", 3000, 5 * 512 + 1);
  endtask

  task automatic test_sparse();
    ck_div = 3;
    check_valid("sparse_sync", 2000, 0);
    for (int i = 0; i < 3; i++) check_valid("sparse", 2000, 1536);
    repeat (900) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({mclk, sclk, lrck, snd_valid, locked} !== 5'b0 || snd_l !== 16'sd0 || snd_r !== 16'sd0) begin
      errors++;
      $display("FAIL midframe_rst: clk/valid/locked=%b l=%h r=%h want all zero", {mclk, sclk, lrck, snd_valid, locked}, snd_l, snd_r);
    end
    rst = 1'b0; en = 1'b0; ck_div = 1;
  endtask

  task automatic test_hpf();
    int prev, n;
    bit ok;
    mode_rand = 1'b0; fix_l = 16'h1000; fix_r = 16'h0000; slot0_bit = 1'b0; fill_bit = 1'b0;
    new_frame();
    en = 1'b1;
    wait_valid(3000, n, ok);
    checks++;
    if (!ok || snd_l !== 16'sh1000) begin errors++; $display("FAIL hpf_first: ok %0d got %h want 1000", ok, snd_l); end
    prev = snd_l;
    for (int i = 0; i < 30; i++) begin
      wait_valid(600, n, ok);
      checks++;
      if (!ok || int'(snd_l) > prev || int'(snd_l) < -1) begin
        errors++; $display("FAIL hpf_decay: ok %0d got %0d prev %0d", ok, snd_l, prev);
      end
      prev = snd_l;
    end
    checks++;
    if (prev >= 16'sh1000) begin errors++; $display("FAIL hpf_moved: got %0d want below 4096", prev); end
  endtask

  initial begin
    test_reset();
`ifdef I2S_ADC_RX_HPF_EN
    test_hpf();
`else
    test_capture();
    test_clocks();
    test_random();
    test_slot_align();
    test_abort();
    test_sparse();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end
endmodule
